// File: rtl/semafor_pkg.sv
// semafor_pkg: light codes, FSM state / phase encoding and code decoder shared by
// the traffic-light monitor and the controller testbenches.
package semafor_pkg;

  localparam logic [2:0] CodeRed    = 3'b100;
  localparam logic [2:0] CodeYellow = 3'b010;
  localparam logic [2:0] CodeGreen  = 3'b001;

  // FSM state; the same encoding is driven out as the phase code.
  typedef logic [1:0] state_t;
  localparam state_t StUnk    = 2'd0;
  localparam state_t StGreen  = 2'd1;
  localparam state_t StRed    = 2'd2;
  localparam state_t StYellow = 2'd3;

  // Any code that is not exactly one light maps to StUnk.
  function automatic state_t code_to_state(input logic [2:0] code);
    state_t st;
    case (code)
      CodeRed:    st = StRed;
      CodeYellow: st = StYellow;
      CodeGreen:  st = StGreen;
      default:    st = StUnk;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: CW-bit saturating cycle counter with synchronous restart.
//   clk_i     : clock, rising edge
//   clr_i     : synchronous active-high clear (count -> 0)
//   restart_i : load 1 instead of incrementing
//   count_o   : current count
//   sat_o     : count is at its maximum value
module dwell_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          restart_i,
  output logic [CW-1:0] count_o,
  output logic          sat_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = CW'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign sat_o   = (cnt_q == '1);

endmodule

// File: rtl/semafor_mon.sv
// semafor_mon: passive checker/decoder for the traffic-light controller outputs.
//   clk, clr              : clock and synchronous active-high reset
//   train, divider        : controller inputs, observed only
//   red, yellow, green    : controller light outputs
//   phase                 : decoded phase (0 unk, 1 green, 2 red, 3 yellow)
//   dwell, dwell_valid    : length of the phase just ended, one-cycle update strobe
//   seq_err, dur_err      : sticky sequence / duration error flags
//   cycles_done           : completed green-red-yellow-green cycles, wrapping
module semafor_mon
  import semafor_pkg::*;
#(
  parameter int unsigned CW       = 16,
  parameter int unsigned RED_BASE = 8,
  parameter int unsigned YEL_BASE = 4,
  parameter int unsigned TOL      = 1,
  parameter int unsigned RESP_MAX = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          train,
  input  logic [1:0]    divider,
  input  logic          red,
  input  logic          yellow,
  input  logic          green,
  output logic [1:0]    phase,
  output logic [CW-1:0] dwell,
  output logic          dwell_valid,
  output logic          seq_err,
  output logic          dur_err,
  output logic [7:0]    cycles_done
);

  // Wide enough to hold RESP_MAX + 1, where the timeout counter parks.
  localparam int unsigned TW = $clog2(RESP_MAX + 2);

  // Input sampling stage
  logic [2:0] code_s;
  logic       train_s;
  logic [1:0] div_s;

  always_ff @(posedge clk) begin
    if (clr) begin
      code_s  <= '0;
      train_s <= 1'b0;
      div_s   <= '0;
    end else begin
      code_s  <= {red, yellow, green};
      train_s <= train;
      div_s   <= divider;
    end
  end

  // Monitor state
  logic [2:0]    last_code_q;
  logic          last_train_q;
  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] held_q, held_d;
  logic [CW-1:0] exp_red_q, exp_red_d, exp_yel_q, exp_yel_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic          valid_q, valid_d;
  logic          seq_q, seq_d;
  logic          dur_q, dur_d;
  logic [7:0]    cyc_q, cyc_d;

  logic          change, train_rise, legal, enter_red;
  state_t        new_state;
  logic [CW-1:0] cnt;
  logic          cnt_sat;

  assign change     = (code_s != last_code_q);
  assign train_rise = train_s & ~last_train_q;
  assign new_state  = code_to_state(code_s);

  // The count seen on a change edge is the final length of the phase being left.
  dwell_counter #(
    .CW(CW)
  ) u_dwell_counter (
    .clk_i    (clk),
    .clr_i    (clr),
    .restart_i(change),
    .count_o  (cnt),
    .sat_o    (cnt_sat)
  );

  function automatic logic out_of_tol(input logic [CW-1:0] meas, input logic sat,
                                      input logic [CW-1:0] expv);
    logic [CW-1:0] diff;
    diff = (meas >= expv) ? (meas - expv) : (expv - meas);
    return sat || (diff > CW'(TOL));
  endfunction

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    held_d    = held_q;
    exp_red_d = exp_red_q;
    exp_yel_d = exp_yel_q;
    dwell_d   = dwell_q;
    valid_d   = 1'b0;
    seq_d     = seq_q;
    dur_d     = dur_q;
    cyc_d     = cyc_q;
    legal     = 1'b0;
    enter_red = 1'b0;

    if (state_q == StUnk) begin
      // Silent until the first green; that green is not reported as a dwell.
      if (code_s == CodeGreen) state_d = StGreen;
    end else if (change) begin
      state_d = new_state;
      dwell_d = cnt;
      valid_d = 1'b1;
      legal   = (state_q == StGreen  && code_s == CodeRed && pend_q) ||
                (state_q == StRed    && code_s == CodeYellow)         ||
                (state_q == StYellow && code_s == CodeGreen);
      if (!legal) seq_d = 1'b1;
      if (state_q == StYellow && code_s == CodeGreen) cyc_d = cyc_q + 8'd1;
      if (state_q == StRed && out_of_tol(cnt, cnt_sat, exp_red_q)) dur_d = 1'b1;
      if (state_q == StYellow && out_of_tol(cnt, cnt_sat, exp_yel_q)) dur_d = 1'b1;
    end

    // Expectations for the whole cycle are frozen at red entry.
    enter_red = (state_d == StRed) && (state_q != StRed);
    if (enter_red) begin
      exp_red_d = CW'(RED_BASE) << div_s;
      exp_yel_d = CW'(YEL_BASE) << div_s;
    end

    // Train edge is judged against the state after this cycle's code change.
    if (enter_red || state_d == StUnk) begin
      pend_d = 1'b0;
    end else if (state_d == StGreen && train_rise) begin
      pend_d = 1'b1;
    end

    // A timeout coinciding with the clearing of train_pend is not an error.
    if (!pend_d) begin
      held_d = '0;
    end else if (pend_q) begin
      if (held_q == TW'(RESP_MAX)) seq_d = 1'b1;
      if (held_q <= TW'(RESP_MAX)) held_d = held_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      last_code_q  <= '0;
      last_train_q <= 1'b0;
      state_q      <= StUnk;
      pend_q       <= 1'b0;
      held_q       <= '0;
      exp_red_q    <= CW'(RED_BASE);
      exp_yel_q    <= CW'(YEL_BASE);
      dwell_q      <= '0;
      valid_q      <= 1'b0;
      seq_q        <= 1'b0;
      dur_q        <= 1'b0;
      cyc_q        <= '0;
    end else begin
      last_code_q  <= code_s;
      last_train_q <= train_s;
      state_q      <= state_d;
      pend_q       <= pend_d;
      held_q       <= held_d;
      exp_red_q    <= exp_red_d;
      exp_yel_q    <= exp_yel_d;
      dwell_q      <= dwell_d;
      valid_q      <= valid_d;
      seq_q        <= seq_d;
      dur_q        <= dur_d;
      cyc_q        <= cyc_d;
    end
  end

  assign phase       = state_q;
  assign dwell       = dwell_q;
  assign dwell_valid = valid_q;
  assign seq_err     = seq_q;
  assign dur_err     = dur_q;
  assign cycles_done = cyc_q;

endmodule

// File: doc/semafor_mon.md
# semafor_mon

Passive protocol checker and decoder for the traffic-light controller's `red`/`yellow`/`green` outputs. It watches the lights, the `train` request strobe and the `divider` setting, and decodes the current light phase. It measures the dwell time of each phase in clock cycles and flags illegal sequences and out-of-tolerance durations. It sits beside the controller in both simulation and on-chip builds and drives nothing back into the controller.

## Interface
Parameters:
- `CW`, 16: width of the dwell counter and of `dwell`.
- `RED_BASE`, 8: expected red dwell at `divider`=0, in cycles.
- `YEL_BASE`, 4: expected yellow dwell at `divider`=0, in cycles.
- `TOL`, 1: allowed absolute deviation of a measured dwell, in cycles.
- `RESP_MAX`, 16: maximum number of cycles from a `train` rise to red.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `clr`  in  1  synchronous active-high reset.
- `train`  in  1  train request strobe, the same signal the controller sees.
- `divider`  in  2  the controller's timing divider.
- `red`, `yellow`, `green`  in  1 each  controller light outputs.
- `phase`  out  2  decoded phase: 0=UNK, 1=GREEN, 2=RED, 3=YELLOW.
- `dwell`  out  CW  length of the phase just ended, in cycles.
- `dwell_valid`  out  1  one-cycle pulse when `dwell` is updated.
- `seq_err`  out  1  sticky flag: illegal code or transition, or response timeout.
- `dur_err`  out  1  sticky flag: red or yellow dwell out of tolerance.
- `cycles_done`  out  8  count of completed green→red→yellow→green cycles; wraps 255→0.

## Operation
- Input sampling: `{red,yellow,green}`, `train` and `divider` are registered once. All logic below works on the sampled values.
- Light codes: 100=RED, 010=YELLOW, 001=GREEN. Any other code is ILLEGAL.
- FSM states are UNK, GREEN, RED and YELLOW. After `clr` the FSM is in UNK and ignores everything until the first GREEN code, then moves to GREEN with no dwell reported.
- Legal transitions:
  - GREEN→RED, only if `train_pend` is set.
  - RED→YELLOW.
  - YELLOW→GREEN; this increments `cycles_done`.
- Error handling:
  - Any other code change, or an ILLEGAL code outside UNK, sets `seq_err`. The FSM then follows the new code (ILLEGAL → UNK).
  - Tracking continues after an error.
- `train_pend`:
  - Set on a sampled rising edge of `train` while in GREEN.
  - Cleared on entry to RED or UNK.
  - A train edge in any other state is ignored.
- Response timeout: if `train_pend` has been held for more than `RESP_MAX` cycles, `seq_err` is set once.
- Dwell measurement:
  - The counter restarts at 1 on each code change and increments every cycle while the code is stable.
  - It saturates at 2^CW−1.
  - On each change (except out of UNK) the final count is loaded into `dwell` and `dwell_valid` pulses.
- Duration check:
  - The expected values are latched from `divider` on RED entry: red = `RED_BASE`<<`divider`, yellow = `YEL_BASE`<<`divider`.
  - A change of `divider` mid-cycle does not affect the current cycle.
  - A RED or YELLOW dwell with |measured − expected| > `TOL` sets `dur_err`. A saturated count always fails. GREEN dwell is not checked.
- `phase` mirrors the FSM state.

## Timing
- Reset values: `phase`=0, `dwell`=0, `dwell_valid`=0, `seq_err`=0, `dur_err`=0, `cycles_done`=0. Internal counters and `train_pend` are also cleared.
- `clr` asserted mid-cycle takes effect at the next edge, and the block resumes in UNK.
- Latency: `phase`, `dwell`, `dwell_valid`, the error flags and `cycles_done` all update 2 clk edges after the first edge at which a new light code is present on the pins.
- The sticky flags clear only on `clr`.
- If a code change and a train edge occur in the same cycle, the code change is evaluated first. The train edge is then judged against the new state.
- If a timeout and a legal GREEN→RED occur in the same cycle, no error is raised; RED wins.

## Structure
- Package `semafor_pkg`: light code constants (RED/YELLOW/GREEN), the `phase` encoding, and the FSM state typedef. The controller testbenches share this package.
- One sub-module, `dwell_counter` (a CW-bit saturating counter with restart), instantiated once.
- The FSM, `train_pend`, the timeout counter and the tolerance comparator live in the top module.

## Test plan
- Nominal cycle: `RED_BASE`=8, `YEL_BASE`=4, `TOL`=1, `divider`=0. A 4-cycle `train` pulse, red for 8, yellow for 4, then green → `dwell` reports 8 then 4. `cycles_done`=1, both error flags 0.
- Divider sweep: `divider`=0..3 over four cycles → red dwell 8/16/32/64 and yellow 4/8/16/32 all accepted. A `divider` change during red uses the old value.
- Tolerance: red held 10 cycles at `divider`=0 → `dur_err`=1. Red held 9 cycles → `dur_err` stays 0.
- Illegal sequences:
  - GREEN→YELLOW → `seq_err`=1.
  - Code 110 → `seq_err`=1 and `phase`=0.
  - GREEN→RED without a train edge → `seq_err`=1.
- Timeout: `train` pulse with green held for 17 cycles (`RESP_MAX`=16) → `seq_err`=1.
- Reset and wrap:
  - `clr` during yellow → all outputs 0; the next green is not reported as a dwell.
  - 256 clean cycles → `cycles_done` wraps to 0.
